// File: rtl/inst_cache_level.sv
// Direct-mapped write-through instruction cache level; hits return the addressed chunk combinationally.
// Misses stall and fill the whole line at the first edge where lower_stall is low; writes stall on lower_stall.
module inst_cache_level #(
  parameter int LINE_BYTES = 64,
  parameter int OUT_BYTES  = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  input  logic                    wenable,
  input  logic [8*LINE_BYTES-1:0] lower_block,
  input  logic                    lower_stall,
  output logic                    stall,
  output logic [8*OUT_BYTES-1:0]  out,
  output logic [31:0]             lower_addr,
  output logic [31:0]             lower_wdata,
  output logic                    lower_wenable,
  output logic                    lower_renable
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int OUT_W  = 8 * OUT_BYTES;
  localparam int CHUNKS = LINE_BYTES / OUT_BYTES;
  localparam int WORDS  = LINE_BYTES / 4;

  logic [OFF_W-1:0]     offset;
  logic [IDX_W-1:0]     index;
  logic [TAG_W-1:0]     tag;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic [LINE_W-1:0]    line, line_wr;
  logic                 hit, fill_en, wr_en;
  int                   chunk_lo, word_lo;

  assign offset = addr[OFF_W-1:0];
  assign index  = addr[OFF_W +: IDX_W];
  assign tag    = addr[31 -: TAG_W];
  assign line   = data_q[index];
  assign hit    = valid_q[index] && (tag_q[index] == tag);

  // Byte 0 of a line sits in the MSBs, so chunk/word positions count down from the top.
  always_comb begin
    chunk_lo = (CHUNKS - 1 - int'(offset) / OUT_BYTES) * OUT_W;
    word_lo  = (WORDS - 1 - int'(offset) / 4) * 32;
    line_wr  = line;
    line_wr[word_lo +: 32] = wdata;
  end

  // Writes and fills are mutually exclusive through wenable, giving writes priority.
  assign wr_en   = reset && wenable && hit && !lower_stall;
  assign fill_en = reset && !wenable && !hit && !lower_stall;

  always_comb begin
    stall         = 1'b0;
    out           = '0;
    lower_addr    = '0;
    lower_wdata   = '0;
    lower_wenable = 1'b0;
    lower_renable = 1'b0;
    if (reset) begin
      out = line[chunk_lo +: OUT_W];
      if (wenable) begin
        stall         = lower_stall;
        lower_addr    = addr;
        lower_wdata   = wdata;
        lower_wenable = 1'b1;
        lower_renable = 1'b1;
      end else if (!hit) begin
        stall         = 1'b1;
        lower_addr    = {addr[31:OFF_W], {OFF_W{1'b0}}};
        lower_renable = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (fill_en) valid_d[index] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tags and data need no reset: they are only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[index]  <= tag;
      data_q[index] <= lower_block;
    end else if (wr_en) begin
      data_q[index] <= line_wr;
    end
  end

endmodule

// File: tb/tb_inst_cache_level.sv
// Bench for inst_cache_level: L1-configured instance driven from a vector table, plus an L3-configured instance.
module tb_inst_cache_level;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [31:0]   addr, wdata, lower_addr, lower_wdata;
  logic          wenable, lower_stall, stall, lower_wenable, lower_renable;
  logic [511:0]  lower_block;
  logic [31:0]   out;

  logic [31:0]   addr3, wdata3, lower_addr3, lower_wdata3;
  logic          wenable3, lower_stall3, stall3, lower_wenable3, lower_renable3;
  logic [2047:0] lower_block3;
  logic [1023:0] out3;

  inst_cache_level dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .wenable(wenable),
    .lower_block(lower_block), .lower_stall(lower_stall), .stall(stall), .out(out),
    .lower_addr(lower_addr), .lower_wdata(lower_wdata), .lower_wenable(lower_wenable),
    .lower_renable(lower_renable)
  );

  inst_cache_level #(.LINE_BYTES(256), .OUT_BYTES(128), .NUM_LINES(16)) dut3 (
    .clk(clk), .reset(reset), .addr(addr3), .wdata(wdata3), .wenable(wenable3),
    .lower_block(lower_block3), .lower_stall(lower_stall3), .stall(stall3), .out(out3),
    .lower_addr(lower_addr3), .lower_wdata(lower_wdata3), .lower_wenable(lower_wenable3),
    .lower_renable(lower_renable3)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic        ls;
    logic [7:0]  seed;
    logic        e_stall, e_ren, e_wen, chk_out;
    logic [31:0] e_out;
  } vec_t;

  typedef struct {
    string         name;
    logic          stall, ren, wen, chk_la, chk_wd, chk_out;
    logic [31:0]   la, wd;
    logic [1023:0] out;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mkv(string n, logic r, logic [31:0] a, logic w, logic [31:0] wd,
                               logic ls, logic [7:0] sd, logic es, logic er, logic ew,
                               logic co, logic [31:0] eo);
    vec_t v;
    v.name = n; v.rst = r; v.addr = a; v.wen = w; v.wdata = wd; v.ls = ls; v.seed = sd;
    v.e_stall = es; v.e_ren = er; v.e_wen = ew; v.chk_out = co; v.e_out = eo;
    return v;
  endfunction

  function automatic logic [31:0] w4(logic [7:0] s);
    logic [7:0] b0, b1, b2, b3;
    b0 = s; b1 = s + 8'd1; b2 = s + 8'd2; b3 = s + 8'd3;
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [511:0] blk64(logic [7:0] s);
    logic [511:0] b;
    for (int i = 0; i < 64; i++) b[511-8*i -: 8] = s + 8'(i);
    return b;
  endfunction

  function automatic logic [1023:0] l3_chunk(logic [7:0] base);
    logic [1023:0] r;
    for (int i = 0; i < 128; i++) r[1023-8*i -: 8] = base + 8'(i);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic compare(input logic s, input logic r, input logic w, input logic [31:0] la,
                         input logic [31:0] wd, input logic [1023:0] o);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = sbq.pop_front();
    chk({e.name, ".stall"}, 256'(s), 256'(e.stall));
    chk({e.name, ".lower_renable"}, 256'(r), 256'(e.ren));
    chk({e.name, ".lower_wenable"}, 256'(w), 256'(e.wen));
    if (e.chk_la) chk({e.name, ".lower_addr"}, 256'(la), 256'(e.la));
    if (e.chk_wd) chk({e.name, ".lower_wdata"}, 256'(wd), 256'(e.wd));
    if (e.chk_out)
      for (int k = 0; k < 4; k++)
        chk($sformatf("%s.out[%0d]", e.name, k), o[k*256 +: 256], e.out[k*256 +: 256]);
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    reset = v.rst; addr = v.addr; wenable = v.wen; wdata = v.wdata;
    lower_stall = v.ls; lower_block = blk64(v.seed);
    e.name = v.name; e.stall = v.e_stall; e.ren = v.e_ren; e.wen = v.e_wen;
    e.chk_la = v.e_ren; e.la = v.wen ? v.addr : (v.addr & 32'hFFFF_FFC0);
    e.chk_wd = v.e_wen; e.wd = v.wdata;
    e.chk_out = v.chk_out; e.out = {992'b0, v.e_out};
    sbq.push_back(e);
    #1 compare(stall, lower_renable, lower_wenable, lower_addr, lower_wdata, {992'b0, out});
  endtask

  task automatic apply3(input string n, input logic [31:0] a, input logic ls, input logic es,
                        input logic co, input logic [1023:0] eo);
    exp_t e;
    @(negedge clk);
    addr3 = a; lower_stall3 = ls;
    e.name = n; e.stall = es; e.ren = es; e.wen = 1'b0;
    e.chk_la = es; e.la = a & 32'hFFFF_FF00; e.chk_wd = 1'b0; e.wd = '0;
    e.chk_out = co; e.out = eo;
    sbq.push_back(e);
    #1 compare(stall3, lower_renable3, lower_wenable3, lower_addr3, lower_wdata3, out3);
  endtask

  initial begin
    reset = 1'b1; addr = '0; wdata = '0; wenable = 1'b0; lower_stall = 1'b1; lower_block = '0;
    addr3 = '0; wdata3 = '0; wenable3 = 1'b0; lower_stall3 = 1'b1;
    for (int i = 0; i < 256; i++) lower_block3[2047-8*i -: 8] = 8'(i);
    #1 reset = 1'b0;

    //            name            rst addr          wen wdata          ls  seed   st ren wen co  out
    vecs.push_back(mkv("rst_state",  0, 32'h40,    0, 32'h0,        1, 8'h00, 0, 0, 0, 1, 32'h0));
    vecs.push_back(mkv("cold_miss",  1, 32'h40,    0, 32'h0,        0, 8'h00, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mkv("cold_hit",   1, 32'h40,    0, 32'h0,        0, 8'h00, 0, 0, 0, 1, w4(8'h00)));
    vecs.push_back(mkv("hit_4c",     1, 32'h4C,    0, 32'h0,        0, 8'h00, 0, 0, 0, 1, w4(8'h0C)));
    vecs.push_back(mkv("wait0",      1, 32'h1000,  0, 32'h0,        1, 8'h80, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mkv("wait1",      1, 32'h1000,  0, 32'h0,        1, 8'h80, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mkv("wait2",      1, 32'h1000,  0, 32'h0,        1, 8'h80, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mkv("wait3",      1, 32'h1000,  0, 32'h0,        0, 8'h80, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mkv("wait_hit",   1, 32'h1000,  0, 32'h0,        0, 8'h80, 0, 0, 0, 1, w4(8'h80)));
    vecs.push_back(mkv("conf_a",     1, 32'h0,     0, 32'h0,        0, 8'h20, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mkv("conf_a_hit", 1, 32'h0,     0, 32'h0,        0, 8'h20, 0, 0, 0, 1, w4(8'h20)));
    vecs.push_back(mkv("conf_b",     1, 32'h400,   0, 32'h0,        0, 8'h40, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mkv("conf_b_hit", 1, 32'h400,   0, 32'h0,        0, 8'h40, 0, 0, 0, 1, w4(8'h40)));
    vecs.push_back(mkv("conf_a2",    1, 32'h0,     0, 32'h0,        0, 8'h60, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mkv("conf_a2_hit",1, 32'h0,     0, 32'h0,        0, 8'h60, 0, 0, 0, 1, w4(8'h60)));
    vecs.push_back(mkv("wr_44",      1, 32'h44,    1, 32'hDEADBEEF, 0, 8'hF0, 0, 1, 1, 0, 32'h0));
    vecs.push_back(mkv("rd_44",      1, 32'h44,    0, 32'h0,        0, 8'hF0, 0, 0, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mkv("rd_40",      1, 32'h40,    0, 32'h0,        0, 8'hF0, 0, 0, 0, 1, w4(8'h00)));
    vecs.push_back(mkv("wr_wait",    1, 32'h48,    1, 32'h11223344, 1, 8'hF0, 1, 1, 1, 0, 32'h0));
    vecs.push_back(mkv("wr_go",      1, 32'h48,    1, 32'h11223344, 0, 8'hF0, 0, 1, 1, 0, 32'h0));
    vecs.push_back(mkv("rd_48",      1, 32'h48,    0, 32'h0,        0, 8'hF0, 0, 0, 0, 1, 32'h11223344));
    vecs.push_back(mkv("wr_unal",    1, 32'h4E,    1, 32'hCAFEF00D, 0, 8'hF0, 0, 1, 1, 0, 32'h0));
    vecs.push_back(mkv("rd_4c",      1, 32'h4C,    0, 32'h0,        0, 8'hF0, 0, 0, 0, 1, 32'hCAFEF00D));
    vecs.push_back(mkv("wr_noalloc", 1, 32'h2000,  1, 32'h12345678, 0, 8'hF0, 0, 1, 1, 0, 32'h0));
    vecs.push_back(mkv("rd_2000",    1, 32'h2000,  0, 32'h0,        1, 8'h90, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mkv("rst_fill",   0, 32'h2000,  0, 32'h0,        1, 8'h90, 0, 0, 0, 1, 32'h0));
    vecs.push_back(mkv("rst_hold",   0, 32'h2000,  0, 32'h0,        0, 8'h90, 0, 0, 0, 1, 32'h0));
    vecs.push_back(mkv("post_rst40", 1, 32'h40,    0, 32'h0,        1, 8'h90, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mkv("post_rst2k", 1, 32'h2000,  0, 32'h0,        0, 8'hA0, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mkv("refill_hit", 1, 32'h2000,  0, 32'h0,        0, 8'hA0, 0, 0, 0, 1, w4(8'hA0)));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // L3 geometry: 0x180 sits in the upper half of the 256-byte block at 0x100.
    apply3("l3_miss",  32'h180, 1'b0, 1'b1, 1'b0, '0);
    apply3("l3_hi",    32'h180, 1'b0, 1'b0, 1'b1, l3_chunk(8'h80));
    apply3("l3_lo",    32'h100, 1'b0, 1'b0, 1'b1, l3_chunk(8'h00));
    apply3("l3_other", 32'h200, 1'b1, 1'b1, 1'b0, '0);

    if (sbq.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_left actual=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
